// File: rtl/excitation_state_reg_pkg.sv
// Shared definitions for the excitation state register and its flip-flop cells:
// FSM encoding, flip-flop mode constants and run stop-cause codes.
package excitation_state_reg_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned CAUSE_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } fsm_state_e;

   localparam logic MODE_D = 1'b0;
   localparam logic MODE_T = 1'b1;

   typedef enum logic [CAUSE_W-1:0] {
      CAUSE_NONE  = 2'b00,
      CAUSE_STUCK = 2'b01,
      CAUSE_LOOP  = 2'b10,
      CAUSE_MAX   = 2'b11
   } cause_e;

   // Next state implied by an excitation vector for the selected flip-flop type.
   function automatic logic [STATE_W-1:0] excite_next(
      input logic               mode,
      input logic [STATE_W-1:0] q,
      input logic [STATE_W-1:0] d_exc,
      input logic [STATE_W-1:0] t_exc
   );
      return (mode == MODE_T) ? (q ^ t_exc) : d_exc;
   endfunction

endpackage

// File: rtl/excitation_state_reg_ff_dt_cell.sv
// Single state bit usable as a D or T flip-flop, with synchronous load.
// Ports:
//   clk, reset         clock, async active-high reset (q -> 0)
//   load_en, load_val  load load_val this edge (has priority over en)
//   en                 commit one update this edge
//   mode               MODE_D: q <= d_in, MODE_T: q <= q ^ t_in
//   d_in, t_in         D and T excitations for this bit
//   q                  registered bit value
module ff_dt_cell
   import excitation_state_reg_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic load_en,
   input  logic load_val,
   input  logic en,
   input  logic mode,
   input  logic d_in,
   input  logic t_in,
   output logic q
);

   logic q_q;
   logic q_d;

   // Next value: load, else enabled D/T update, else hold.
   always_comb begin
      q_d = q_q;
      if (load_en) begin
         q_d = load_val;
      end else if (en) begin
         q_d = (mode == MODE_T) ? (q_q ^ t_in) : d_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/excitation_state_reg.sv
// Three-bit state register behind the next-state excitation logic, with a run
// controller that loads an initial state, steps under step_en, counts steps
// and stops on stuck / loop-to-initial / step limit.
// Ports:
//   clk, reset          clock, async active-high reset
//   start               load init_state and run (honoured in IDLE and DONE)
//   mode                0 = D update, 1 = T update; latched at LOAD
//   step_en             commit one step this cycle while running
//   init_state          initial state {a,b,c}
//   x_in / x_out        external input, passed straight through
//   d_next, t_next      D and T excitations from the next-state logic
//   state               present state {a,b,c}
//   busy, done          run in progress / run finished
//   done_cause          00 none, 01 stuck, 10 loop, 11 max
//   steps               steps taken in the current run
module excitation_state_reg
   import excitation_state_reg_pkg::*;
#(
   parameter int unsigned STEP_W    = 4,
   parameter int unsigned MAX_STEPS = 12
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               mode,
   input  logic               step_en,
   input  logic [STATE_W-1:0] init_state,
   input  logic               x_in,
   input  logic [STATE_W-1:0] d_next,
   input  logic [STATE_W-1:0] t_next,
   output logic [STATE_W-1:0] state,
   output logic               x_out,
   output logic               busy,
   output logic               done,
   output logic [CAUSE_W-1:0] done_cause,
   output logic [STEP_W-1:0]  steps
);

   fsm_state_e          fsm_q, fsm_d;
   logic [STEP_W-1:0]   steps_q, steps_d;
   cause_e              cause_q, cause_d;
   logic                mode_q, mode_d;
   logic [STATE_W-1:0]  init_q, init_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   logic                load_c;
   logic                step_c;
   logic [STATE_W-1:0]  nxt_c;
   logic [STEP_W-1:0]   steps_inc_c;

   assign x_out = x_in;

   // State bits: loaded in LOAD, updated on committed steps.
   for (genvar i = 0; i < STATE_W; i++) begin : g_bit
      ff_dt_cell u_cell (
         .clk      (clk),
         .reset    (reset),
         .load_en  (load_c),
         .load_val (init_state[i]),
         .en       (step_c),
         .mode     (mode_q),
         .d_in     (d_next[i]),
         .t_in     (t_next[i]),
         .q        (state[i])
      );
   end

   assign nxt_c       = excite_next(mode_q, state, d_next, t_next);
   assign steps_inc_c = STEP_W'(steps_q + STEP_W'(1));

   // Run controller: next state, counter and stop detection.
   always_comb begin
      fsm_d   = fsm_q;
      steps_d = steps_q;
      cause_d = cause_q;
      mode_d  = mode_q;
      init_d  = init_q;
      load_c  = 1'b0;
      step_c  = 1'b0;

      unique case (fsm_q)
         ST_IDLE: begin
            if (start) fsm_d = ST_LOAD;
         end
         ST_LOAD: begin
            load_c  = 1'b1;
            init_d  = init_state;
            mode_d  = mode;
            steps_d = '0;
            cause_d = CAUSE_NONE;
            fsm_d   = ST_RUN;
         end
         ST_RUN: begin
            if (step_en) begin
               step_c  = 1'b1;
               steps_d = steps_inc_c;
               // Stuck outranks loop, which outranks the step limit.
               if (nxt_c == state) begin
                  cause_d = CAUSE_STUCK;
                  fsm_d   = ST_DONE;
               end else if (nxt_c == init_q) begin
                  cause_d = CAUSE_LOOP;
                  fsm_d   = ST_DONE;
               end else if (steps_inc_c == STEP_W'(MAX_STEPS)) begin
                  cause_d = CAUSE_MAX;
                  fsm_d   = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            if (start) fsm_d = ST_LOAD;
         end
         default: fsm_d = ST_IDLE;
      endcase

      busy_d = (fsm_d == ST_LOAD) || (fsm_d == ST_RUN);
      done_d = (fsm_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_q   <= ST_IDLE;
         steps_q <= '0;
         cause_q <= CAUSE_NONE;
         mode_q  <= MODE_D;
         init_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         steps_q <= steps_d;
         cause_q <= cause_d;
         mode_q  <= mode_d;
         init_q  <= init_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign done_cause = cause_q;
   assign steps      = steps_q;

endmodule

// File: doc/excitation_state_reg.md
Name: excitation_state_reg

Overview:
- Sequential state-holding stage that sits directly downstream of the team's 3-bit next-state excitation logic.
- Latches the D or T excitation vector into a 3-bit state register and feeds the state back as the logic's present-state inputs {a,b,c}. The external input x_in is passed through as the logic's d input.
- Adds a run controller on top of the register. The controller loads an initial state, steps under an enable, counts steps, and stops when the machine sticks, loops back, or reaches a step limit.

Parameters:
- STEP_W, 4, width of the step counter.
- MAX_STEPS, 12, step limit; must satisfy 1 ≤ MAX_STEPS ≤ 2^STEP_W − 1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request to load init_state and run (level, sampled each clock)
- mode  in  1  0 = D flip-flop update, 1 = T flip-flop update; sampled only in LOAD
- step_en  in  1  advance one step this cycle while in RUN
- init_state  in  3  initial state {a,b,c}
- x_in  in  1  external input, forwarded combinationally to x_out
- d_next  in  3  D excitations {Da,Db,Dc} from the next-state logic
- t_next  in  3  T excitations {Ta,Tb,Tc} from the next-state logic
- state  out  3  present state {a,b,c}, fed back to the next-state logic
- x_out  out  1  equals x_in (drives the logic's d input)
- busy  out  1  high in LOAD and RUN
- done  out  1  high in DONE
- done_cause  out  2  stop reason: 00 none, 01 stuck, 10 loop, 11 max
- steps  out  STEP_W  number of steps taken in the current run

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on port reset.
- Reset value of every output: state=000, busy=0, done=0, done_cause=00, steps=0, FSM=IDLE, latched mode_q=0. Reset takes effect immediately at any point, including mid-run, and no partial step is committed.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - State register holds its value.
  - start=1 → LOAD on the next edge.
- LOAD (exactly 1 cycle):
  - state←init_state, steps←0, done_cause←00, mode_q←mode.
  - Then → RUN.
- RUN, computation each cycle:
  - nxt = d_next when mode_q=0; nxt = state XOR t_next when mode_q=1.
- RUN, on a cycle with step_en=1:
  - state←nxt, steps←steps+1.
  - Stop checks are evaluated on the values for this step, in priority order:
    1. nxt == state → cause 01 (stuck), → DONE.
    2. nxt == loaded initial state → cause 10 (loop), → DONE.
    3. steps+1 == MAX_STEPS → cause 11 (max), → DONE.
  - The committed step is counted even when it triggers DONE.
- RUN, on a cycle with step_en=0: full hold of state, steps and FSM.
- DONE:
  - state, steps and done_cause frozen.
  - start=1 → LOAD; this is a new run and clears cause and steps.
- start is ignored in LOAD and RUN; there is no abort other than reset.
- mode changes after LOAD have no effect until the next LOAD.
- Loaded initial state: latched internally at LOAD. init_state changes during RUN are ignored.
- steps never wraps, because MAX_STEPS bounds it.
- Latency:
  - start asserted in IDLE → busy=1 one cycle later (LOAD).
  - First step can commit on the edge after LOAD.
  - done rises on the edge that commits the terminating step.
- Outputs are registered except x_out, which is a pure wire.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3).
  - Mode constants MODE_D=1'b0 and MODE_T=1'b1.
  - Cause codes CAUSE_NONE/STUCK/LOOP/MAX.
- One sub-module, ff_dt_cell:
  - Single-bit flip-flop with async reset, load (value), enable and a mode select (D or T).
  - Instantiated 3 times for the state bits.
- Controller, counter and stop detection stay in the top module.

Test Plan:
- D-mode loop: mode=0, init=001, bench drives d_next=state+1 mod 8, step_en=1 → loop after 8 steps: state=001, steps=8, done_cause=10, busy=0, done=1. This needs STEP_W=4 and MAX_STEPS=12.
- T-mode stuck: mode=1, init=101, t_next=000 → DONE after 1 step: state=101, steps=1, cause=01.
- Step limit: MAX_STEPS=5, mode=0, init=000, d_next=state+1 → DONE with state=101, steps=5, cause=11.
- Enable gaps and ignored start: step_en toggling 1,0,0,1 with a start pulse during RUN → steps advances only on enabled cycles and the run is not restarted.
- Reset mid-run: assert reset between edges at steps=3 → all outputs return to reset values immediately. A later start performs a clean LOAD.
- Mode latch and priority: change mode during RUN → no effect. A step where nxt equals both the current state and the initial state → cause 01 (stuck wins over loop).
